// File: rtl/qkv_pkg.sv
// Shared defaults, accumulator-width helper and FSM state type for the
// QKV requantizer and K/V cache.
package qkv_pkg;

  localparam int N_DEF       = 32;
  localparam int DW_DEF      = 4;
  localparam int PE_NUM_DEF  = 12;
  localparam int SEQ_LEN_DEF = 8;

  // Width of a projection accumulator: product of two DW-bit values summed N times.
  function automatic int calc_aw(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/qkv_requant_cache_requant_sat.sv
// Combinational round-half-up arithmetic right shift of one accumulator
// element, saturated to DW signed bits; sat flags a clipped result.
module requant_sat #(
  parameter int DW = 4,
  parameter int AW = 13
) (
  input  logic [AW-1:0] x,
  input  logic [3:0]    shift,
  output logic [DW-1:0] y,
  output logic          sat
);

  localparam logic signed [AW:0] MAX_V = (AW+1)'((1 <<< (DW - 1)) - 1);
  localparam logic signed [AW:0] MIN_V = (AW+1)'(-(1 <<< (DW - 1)));

  logic [3:0]        sh;
  logic [AW:0]       half;
  logic signed [AW:0] xe;
  logic signed [AW:0] rnd;
  logic signed [AW:0] r;

  always_comb begin
    sh   = (int'(shift) >= AW) ? 4'(AW - 1) : shift;
    xe   = {x[AW-1], x};
    // half = 1 << (sh-1), which collapses to 0 when sh is 0
    half = ({{AW{1'b0}}, 1'b1} << sh) >> 1;
    rnd  = $signed(half);
    r    = (xe + rnd) >>> sh;
    y    = r[DW-1:0];
    sat  = 1'b0;
    if (r > MAX_V) begin
      y   = MAX_V[DW-1:0];
      sat = 1'b1;
    end else if (r < MIN_V) begin
      y   = MIN_V[DW-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/qkv_requant_cache.sv
// Requantizes one token of Q/K/V projections head-by-head, presents Q on a
// valid/ready port and appends K/V to a masked cache. Option: QKV_SAT_CNT_EN.
module qkv_requant_cache
  import qkv_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int DW      = DW_DEF,
  parameter int PE_NUM  = PE_NUM_DEF,
  parameter int SEQ_LEN = SEQ_LEN_DEF
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [PE_NUM-1:0][calc_aw(DW, N)-1:0]     in_q,
  input  logic [PE_NUM-1:0][calc_aw(DW, N)-1:0]     in_k,
  input  logic [PE_NUM-1:0][calc_aw(DW, N)-1:0]     in_v,
  input  logic [3:0]                                shift,
  input  logic                                      clear,
  output logic                                      q_valid,
  input  logic                                      q_ready,
  output logic [PE_NUM-1:0][DW-1:0]                 q_out,
  input  logic [$clog2(SEQ_LEN)-1:0]                kv_rd_addr,
  output logic [PE_NUM-1:0][DW-1:0]                 k_rd,
  output logic [PE_NUM-1:0][DW-1:0]                 v_rd,
  output logic [$clog2(SEQ_LEN+1)-1:0]              tok_count,
  output logic                                      cache_full
`ifdef QKV_SAT_CNT_EN
  ,
  output logic [15:0]                               sat_count
`endif
);

  localparam int AW = calc_aw(DW, N);
  localparam int HW = $clog2(PE_NUM);
  localparam int PW = $clog2(SEQ_LEN);
  localparam int CW = $clog2(SEQ_LEN + 1);

  state_e                      state_q, state_d;
  logic [HW-1:0]               h_q, h_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]               tok_count_q, tok_count_d;
  logic [3:0]                  shift_q, shift_d;
  logic [PE_NUM-1:0][AW-1:0]   xq_q, xq_d, xk_q, xk_d, xv_q, xv_d;
  logic [PE_NUM-1:0][DW-1:0]   q_buf_q, q_buf_d;
  logic [PE_NUM-1:0][DW-1:0]   k_rd_q, k_rd_d, v_rd_q, v_rd_d;
  logic [PE_NUM-1:0][DW-1:0]   kmem [SEQ_LEN];
  logic [PE_NUM-1:0][DW-1:0]   vmem [SEQ_LEN];

  logic [2:0][AW-1:0]          x_sel;
  logic [2:0][DW-1:0]          y_sel;
  logic [2:0]                  sat_sel;
  logic                        accept;
  logic                        clear_eff;
  logic                        rd_hit;

  assign cache_full = (tok_count_q == CW'(SEQ_LEN));
  assign in_ready   = (state_q == IDLE) && !cache_full && !clear;
  assign accept     = in_valid && in_ready;
  assign clear_eff  = (state_q == IDLE) && clear;
  assign q_valid    = (state_q == HOLD);
  assign q_out      = q_buf_q;
  assign k_rd       = k_rd_q;
  assign v_rd       = v_rd_q;
  assign tok_count  = tok_count_q;

  assign x_sel[0] = xq_q[h_q];
  assign x_sel[1] = xk_q[h_q];
  assign x_sel[2] = xv_q[h_q];

  for (genvar gi = 0; gi < 3; gi++) begin : g_rq
    requant_sat #(.DW(DW), .AW(AW)) u_rq (
      .x     (x_sel[gi]),
      .shift (shift_q),
      .y     (y_sel[gi]),
      .sat   (sat_sel[gi])
    );
  end

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    wr_ptr_d    = wr_ptr_q;
    tok_count_d = tok_count_q;
    shift_d     = shift_q;
    xq_d        = xq_q;
    xk_d        = xk_q;
    xv_d        = xv_q;
    q_buf_d     = q_buf_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          wr_ptr_d    = '0;
          tok_count_d = '0;
        end else if (accept) begin
          xq_d    = in_q;
          xk_d    = in_k;
          xv_d    = in_v;
          shift_d = shift;
          h_d     = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        q_buf_d[h_q] = y_sel[0];
        if (h_q == HW'(PE_NUM - 1)) begin
          h_d         = '0;
          wr_ptr_d    = (wr_ptr_q == PW'(SEQ_LEN - 1)) ? '0 : wr_ptr_q + 1'b1;
          tok_count_d = tok_count_q + 1'b1;
          state_d     = HOLD;
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      HOLD: begin
        if (q_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Slots at or beyond tok_count read as zero, so stale RAM contents never leak.
  always_comb begin
    rd_hit = CW'(kv_rd_addr) < tok_count_q;
    k_rd_d = rd_hit ? kmem[kv_rd_addr] : '0;
    v_rd_d = rd_hit ? vmem[kv_rd_addr] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      h_q         <= '0;
      wr_ptr_q    <= '0;
      tok_count_q <= '0;
      shift_q     <= '0;
      xq_q        <= '0;
      xk_q        <= '0;
      xv_q        <= '0;
      q_buf_q     <= '0;
      k_rd_q      <= '0;
      v_rd_q      <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      wr_ptr_q    <= wr_ptr_d;
      tok_count_q <= tok_count_d;
      shift_q     <= shift_d;
      xq_q        <= xq_d;
      xk_q        <= xk_d;
      xv_q        <= xv_d;
      q_buf_q     <= q_buf_d;
      k_rd_q      <= k_rd_d;
      v_rd_q      <= v_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && state_q == CONV) begin
      kmem[wr_ptr_q][h_q] <= y_sel[1];
      vmem[wr_ptr_q][h_q] <= y_sel[2];
    end
  end

`ifdef QKV_SAT_CNT_EN
  logic [15:0] sat_count_q, sat_count_d;
  logic [16:0] sat_sum;

  always_comb begin
    sat_sum     = {1'b0, sat_count_q} + 17'({1'b0, sat_sel[0]} + {1'b0, sat_sel[1]} + {1'b0, sat_sel[2]});
    sat_count_d = sat_count_q;
    if (clear_eff) begin
      sat_count_d = '0;
    end else if (state_q == CONV) begin
      sat_count_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) sat_count_q <= '0;
    else      sat_count_q <= sat_count_d;
  end

  assign sat_count = sat_count_q;
`else
  logic [2:0] sat_unused;
  logic       clear_eff_unused;
  assign sat_unused       = sat_sel;
  assign clear_eff_unused = clear_eff;
`endif

endmodule

// File: tb/tb_qkv_requant_cache.sv
// Scoreboard bench for qkv_requant_cache: directed tokens push expected Q
// vectors; a monitor pops and compares on every q_valid/q_ready handshake.
module tb_qkv_requant_cache;

  localparam int N   = 32;
  localparam int DW  = 4;
  localparam int PE  = 12;
  localparam int SEQ = 8;
  localparam int AW  = 13;

  typedef logic [PE-1:0][AW-1:0] xvec_t;
  typedef logic [PE-1:0][DW-1:0] yvec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        clear = 1'b0;
  logic        q_ready = 1'b1;
  logic        in_ready, q_valid, cache_full;
  xvec_t       in_q = '0, in_k = '0, in_v = '0;
  logic [3:0]  shift = 4'd0;
  yvec_t       q_out, k_rd, v_rd;
  logic [2:0]  kv_rd_addr = 3'd0;
  logic [3:0]  tok_count;
`ifdef QKV_SAT_CNT_EN
  logic [15:0] sat_count;
`endif

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    txn = 0;
  yvec_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qkv_requant_cache #(.N(N), .DW(DW), .PE_NUM(PE), .SEQ_LEN(SEQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_q       (in_q),
    .in_k       (in_k),
    .in_v       (in_v),
    .shift      (shift),
    .clear      (clear),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .q_out      (q_out),
    .kv_rd_addr (kv_rd_addr),
    .k_rd       (k_rd),
    .v_rd       (v_rd),
    .tok_count  (tok_count),
    .cache_full (cache_full)
`ifdef QKV_SAT_CNT_EN
    ,
    .sat_count  (sat_count)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic xvec_t xall(input int v);
    xvec_t r;
    for (int h = 0; h < PE; h++) r[h] = 13'(v);
    return r;
  endfunction

  function automatic yvec_t yall(input int v);
    yvec_t r;
    for (int h = 0; h < PE; h++) r[h] = 4'(v);
    return r;
  endfunction

  // Present a token, wait (bounded) for acceptance, queue its expected Q.
  task automatic send(input xvec_t q, input xvec_t k, input xvec_t v, input logic [3:0] sh,
                      input yvec_t eq, output int acc);
    int n;
    n = 0;
    in_q = q; in_k = k; in_v = v; shift = sh; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=0 required 1");
      in_valid = 1'b0;
      acc = cyc;
    end else begin
      exp_q.push_back(eq);
      tick();
      acc = cyc;
      in_valid = 1'b0;
    end
  endtask

  // Edges from the accepting edge until q_valid is seen; 12 edges puts
  // q_valid in cycle 13 when the acceptance cycle is counted as cycle 0.
  task automatic wait_qv(input int acc, input string name);
    int n;
    n = 0;
    while (!q_valid && n < 100) begin
      tick();
      n++;
    end
    chk(name, 64'(cyc - acc), 64'd12);
  endtask

  task automatic rd(input int a, input yvec_t ek, input yvec_t ev, input string nm);
    kv_rd_addr = 3'(a);
    tick();
    chk({nm, "_k"}, 64'(k_rd), 64'(ek));
    chk({nm, "_v"}, 64'(v_rd), 64'(ev));
  endtask

  always @(negedge clk) begin
    if (rst && q_valid && q_ready) begin
      txn++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_q: txn %0d q_out=%h with no expected entry", txn, q_out);
      end else begin
        yvec_t e;
        e = exp_q.pop_front();
        $display("txn %0d q_out=%h expected=%h", txn, q_out, e);
        chk("q_out_txn", 64'(q_out), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int    acc;
    xvec_t qa, ka, qb, qc, qd, qf;
    yvec_t ea, eka, eb, ec, ed, ef;

    // Reset state
    repeat (3) tick();
    chk("rst_q_valid", 64'(q_valid), 64'd0);
    chk("rst_q_out", 64'(q_out), 64'd0);
    chk("rst_tok_count", 64'(tok_count), 64'd0);
    chk("rst_k_rd", 64'(k_rd), 64'd0);
    chk("rst_cache_full", 64'(cache_full), 64'd0);
    rst = 1'b1;
    tick();
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // Token A: shift 2, q[h]=8*min(h+1,7) -> 2,4,6 then saturated 7
    for (int h = 0; h < PE; h++) begin
      qa[h] = 13'(8 * ((h + 1 < 7) ? h + 1 : 7));
      ka[h] = (h == 1) ? 13'(-40) : 13'(12);
      ea[h] = (h == 0) ? 4'd2 : (h == 1) ? 4'd4 : (h == 2) ? 4'd6 : 4'd7;
      eka[h] = (h == 1) ? 4'h8 : 4'd3;
    end
    q_ready = 1'b0;
    send(qa, ka, xall(-12), 4'd2, ea, acc);
    wait_qv(acc, "latency_A");
    in_q = '1; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("hold_q_valid", 64'(q_valid), 64'd1);
      chk("hold_q_out", 64'(q_out), 64'(ea));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    q_ready = 1'b1;
    tick();
    chk("after_hold_q_valid", 64'(q_valid), 64'd0);
    chk("tok_count_1", 64'(tok_count), 64'd1);

    // Token B: shift 1 -> -9:-4, 9:5, -1:0, 15:7(sat)
    qb = '0; eb = '0;
    qb[0] = 13'(-9); qb[1] = 13'd9; qb[2] = 13'(-1); qb[3] = 13'd15;
    eb[0] = 4'hC;    eb[1] = 4'd5;  eb[2] = 4'd0;    eb[3] = 4'd7;
    send(qb, '0, '0, 4'd1, eb, acc);
    wait_qv(acc, "latency_B");
    tick();

    // Token C: shift 0 -> -100:-8, 7:7, -8:-8, 8:7
    qc = '0; ec = '0;
    qc[0] = 13'(-100); qc[1] = 13'd7; qc[2] = 13'(-8); qc[3] = 13'd8;
    ec[0] = 4'h8;      ec[1] = 4'd7;  ec[2] = 4'h8;    ec[3] = 4'd7;
    send(qc, xall(5), xall(-6), 4'd0, ec, acc);
    wait_qv(acc, "latency_C");
    tick();
    chk("tok_count_3", 64'(tok_count), 64'd3);

    // Cache reads with three valid slots
    rd(5, '0, '0, "rd_addr5_masked");
    rd(0, eka, yall(-3), "rd_addr0");
    rd(2, yall(5), yall(-6), "rd_addr2");
    rd(3, '0, '0, "rd_addr3_masked");

    // Token D: shift 15 clamps to 12
    qd = '0; ed = '0;
    qd[0] = 13'd4095; qd[1] = 13'h1000; qd[2] = 13'd2047; qd[3] = 13'd2048;
    ed[0] = 4'd1;     ed[1] = 4'hF;     ed[2] = 4'd0;     ed[3] = 4'd1;
    send(qd, '0, '0, 4'd15, ed, acc);
    wait_qv(acc, "latency_D");
    tick();

    // Fill slots 4..7, shift 0, values pass through unchanged
    for (int t = 4; t < SEQ; t++) begin
      for (int h = 0; h < PE; h++) begin
        qf[h] = 13'(h - 6);
        ef[h] = 4'(h - 6);
      end
      send(qf, xall(t), xall(-t), 4'd0, ef, acc);
      wait_qv(acc, "latency_fill");
      tick();
    end
    chk("full_cache_full", 64'(cache_full), 64'd1);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_tok_count", 64'(tok_count), 64'd8);
    rd(7, yall(7), yall(-7), "rd_addr7");

    // Ninth token held off while full
    in_q = xall(1); in_valid = 1'b1;
    repeat (10) tick();
    chk("ninth_in_ready", 64'(in_ready), 64'd0);
    chk("ninth_tok_count", 64'(tok_count), 64'd8);

    // clear together with in_valid: clear wins, nothing accepted
    clear = 1'b1;
    #1;
    chk("clear_in_ready", 64'(in_ready), 64'd0);
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("clear_tok_count", 64'(tok_count), 64'd0);
    chk("clear_cache_full", 64'(cache_full), 64'd0);
    chk("clear_no_accept", 64'(in_ready), 64'd1);
    rd(0, '0, '0, "rd_after_clear");

    // Reset during CONV: partial token discarded
    in_q = xall(100); in_k = xall(100); in_v = xall(100); shift = 4'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
`ifdef QKV_SAT_CNT_EN
    chk("sat_count_conv5", 64'(sat_count), 64'd15);
`endif
    rst = 1'b0;
    tick();
    chk("midrst_tok_count", 64'(tok_count), 64'd0);
    chk("midrst_q_valid", 64'(q_valid), 64'd0);
    chk("midrst_q_out", 64'(q_out), 64'd0);
`ifdef QKV_SAT_CNT_EN
    chk("midrst_sat_count", 64'(sat_count), 64'd0);
`endif
    rst = 1'b1;
    repeat (15) tick();
    chk("post_rst_q_valid", 64'(q_valid), 64'd0);
    chk("post_rst_tok_count", 64'(tok_count), 64'd0);
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
